// File: rtl/sequence_scan_controller_if.sv
// sequence_scan_controller_if
//   Word-in / result-out bundle for the serial pattern scan controller.
//   master : producer/consumer side (drives in_valid, in_data, res_ready)
//   slave  : controller side (drives in_ready, res_*, det_*, busy)
//   Signals:
//     in_valid/in_ready/in_data  word handshake, in_data[WIDTH-1] scanned first
//     res_valid/res_ready        result handshake
//     res_count/res_found/res_first  per-word hit summary
//     det_bit/det_hit            serial bit and Mealy hit of the current SHIFT cycle
//     busy                       controller not idle
interface sequence_scan_controller_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             res_valid;
    logic             res_ready;
    logic [CW-1:0]    res_count;
    logic             res_found;
    logic [IW-1:0]    res_first;
    logic             det_bit;
    logic             det_hit;
    logic             busy;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_count, res_found, res_first,
               det_bit, det_hit, busy
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_count, res_found, res_first,
               det_bit, det_hit, busy
    );
endinterface

// File: rtl/sequence_scan_controller.sv
// sequence_scan_controller
//   Accepts a word, shifts it MSB-first (one bit per clk) through an
//   overlapping Mealy pattern matcher and reports hit count, found flag and
//   the bit index completing the first hit.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous reset, active-low
//     bus    sequence_scan_controller_if.slave (word/result handshakes,
//            serial det_bit/det_hit monitor taps, busy)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a word, in_ready=1
//   SHIFT | presenting bit idx on det_bit, matching against history
//   DONE  | result held on res_*, waiting for res_ready
module sequence_scan_controller #(
    parameter int                 WIDTH   = 16,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 CHAIN   = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    sequence_scan_controller_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   shreg;
    logic [IW-1:0]      idx;
    logic [PAT_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [CW-1:0]      count;
    logic               found;
    logic [IW-1:0]      first;

    logic               accept;
    logic               last_bit;
    logic               cur_bit;
    logic               hit;
    logic               in_ready_c;
    logic               res_valid_c;
    logic               busy_c;
    logic [PAT_LEN-1:0] window;

    // The word is shifted left, so the bit on det_bit is always the MSB.
    assign cur_bit  = (state == SHIFT) & shreg[WIDTH-1];
    assign window   = {hist, cur_bit};
    assign last_bit = (idx == IDX_LAST);
    // No hit until the history holds PAT_LEN-1 genuine bits.
    assign hit      = (state == SHIFT) && (fill == FILL_MAX) && (window == PATTERN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        in_ready_c  = 1'b0;
        res_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid_c = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
            idx   <= '0;
            hist  <= '0;
            fill  <= '0;
            count <= '0;
            found <= 1'b0;
            first <= '0;
        end else if (accept) begin
            shreg <= bus.in_data;
            idx   <= '0;
            count <= '0;
            found <= 1'b0;
            first <= '0;
            if (!CHAIN) begin
                hist <= '0;
                fill <= '0;
            end
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            // History is never flushed on a hit, so overlapping matches count.
            hist  <= window[PAT_LEN-2:0];
            if (fill != FILL_MAX) begin
                fill <= fill + FW'(1);
            end
            if (!last_bit) begin
                idx <= idx + IW'(1);
            end
            if (hit) begin
                count <= count + CW'(1);
                if (!found) begin
                    found <= 1'b1;
                    first <= idx;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.res_valid = res_valid_c;
    assign bus.busy      = busy_c;
    assign bus.res_count = count;
    assign bus.res_found = found;
    assign bus.res_first = first;
    assign bus.det_bit   = cur_bit;
    assign bus.det_hit   = hit;
endmodule
